sign_pipe: RTL and testbench

Registered, parametrised two's-complement sign-manipulation unit for the register datapath. Each accepted operand is passed through, negated, made absolute, or made negative-absolute according to a per-transaction mode. The result leaves through a valid/ready output register. Unlike the plain combinational negate, it detects the most-negative-value overflow, optionally saturates it, and keeps a saturating count of overflow events.

---
 rtl/sign_pkg.sv | 22 ++
 rtl/sign_op.sv | 45 ++++
 rtl/sign_pipe.sv | 69 ++++++
 tb/tb_sign_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_pkg.sv
// Shared types and constants for the sign manipulation unit.
// Mode encoding and width-parametric MIN/MAX helpers.
package sign_pkg;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    NEG  = 2'b01,
    ABS  = 2'b10,
    NABS = 2'b11
  } sign_mode_t;

  // Most negative n-bit value, zero-extended to 64 bits.
  function automatic logic [63:0] min_val(input int n);
    return 64'd1 << (n - 1);
  endfunction

  // Most positive n-bit value, zero-extended to 64 bits.
  function automatic logic [63:0] max_val(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/sign_op.sv
// Combinational pass/negate/abs/nabs on an N-bit signed operand.
// Flags MIN overflow and clamps or wraps the result.
module sign_op
  import sign_pkg::*;
#(
  parameter int N        = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [N-1:0] x,
  input  sign_mode_t   mode,
  output logic [N-1:0] y,
  output logic         ovf
);

  localparam logic [N-1:0] MIN = N'(min_val(N));
  localparam logic [N-1:0] MAX = N'(max_val(N));
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] neg;
  logic         is_min;

  assign neg    = ~x + ONE;
  assign is_min = (x == MIN);

  // Select the operation, then override overflowing results.
  always_comb begin
    y   = x;
    ovf = 1'b0;
    unique case (mode)
      PASS: y = x;
      NEG: begin
        y   = neg;
        ovf = is_min;
      end
      ABS: begin
        y   = x[N-1] ? neg : x;
        ovf = is_min;
      end
      NABS: y = x[N-1] ? x : neg;
    endcase
    if (ovf)
      y = SATURATE ? MAX : MIN;
  end

endmodule

// File: rtl/sign_pipe.sv
// Registered sign unit: one-entry valid/ready output stage
// plus a saturating overflow event counter.
module sign_pipe
  import sign_pkg::*;
#(
  parameter int N        = 8,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clear
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [N-1:0] op_y;
  logic         op_ovf;
  logic         acc;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  sign_op #(
    .N        (N),
    .SATURATE (SATURATE)
  ) u_op (
    .x    (in_data),
    .mode (sign_mode_t'(in_mode)),
    .y    (op_y),
    .ovf  (op_ovf)
  );

  // Output register: load on accept, drop valid once consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= op_y;
      out_ovf   <= op_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Overflow counter: clear wins, otherwise saturating increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf_count <= '0;
    else if (ovf_clear)
      ovf_count <= '0;
    else if (acc && op_ovf && ovf_count != CMAX)
      ovf_count <= ovf_count + CONE;
  end

endmodule

// File: tb/tb_sign_pipe.sv
// Scoreboard bench for sign_pipe across four parameter sets.
// Directed scenarios plus randomized traffic with a value-level model.
module tb_sign_pipe;
  import sign_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [3:0]  iv, ir, ov, ordy, oo, clr;
  logic [15:0] id [4];
  logic [1:0]  im [4];
  logic [15:0] od [4];
  logic [7:0]  oc [4];

  logic [7:0]  od0, od1, oc0, oc2, oc3;
  logic [3:0]  od2;
  logic [15:0] od3;
  logic [1:0]  oc1;

  assign od[0] = 16'(od0);
  assign od[1] = 16'(od1);
  assign od[2] = 16'(od2);
  assign od[3] = od3;
  assign oc[0] = oc0;
  assign oc[1] = 8'(oc1);
  assign oc[2] = oc2;
  assign oc[3] = oc3;

  int total = 0;
  int bad   = 0;
  int cnt_m [4];
  int qsize [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed integer arithmetic, then range check.
  function automatic logic [16:0] ref_op(input int w, input bit sat,
                                         input logic [1:0] m,
                                         input logic [15:0] x);
    longint msk, v, r, mx, mn;
    bit o;
    msk = (longint'(1) << w) - 1;
    v   = longint'(x) & msk;
    if (v >= (longint'(1) << (w - 1)))
      v = v - (longint'(1) << w);
    case (m)
      2'd0:    r = v;
      2'd1:    r = -v;
      2'd2:    r = (v < 0) ? -v : v;
      default: r = (v < 0) ? v : -v;
    endcase
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    o  = (r > mx);
    if (o)
      r = sat ? mx : mn;
    return {o, 16'(r & msk)};
  endfunction

  function automatic int width_of(input int g);
    return (g == 2) ? 4 : ((g == 3) ? 16 : 8);
  endfunction

  sign_pipe #(.N(8), .SATURATE(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0][7:0]), .in_mode(im[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od0), .out_ovf(oo[0]),
    .ovf_count(oc0), .ovf_clear(clr[0])
  );

  sign_pipe #(.N(8), .SATURATE(1'b1), .CNT_W(2)) u1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1][7:0]), .in_mode(im[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od1), .out_ovf(oo[1]),
    .ovf_count(oc1), .ovf_clear(clr[1])
  );

  sign_pipe #(.N(4), .SATURATE(1'b0), .CNT_W(8)) u2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2][3:0]), .in_mode(im[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od2), .out_ovf(oo[2]),
    .ovf_count(oc2), .ovf_clear(clr[2])
  );

  sign_pipe #(.N(16), .SATURATE(1'b1), .CNT_W(8)) u3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[3]), .in_ready(ir[3]),
    .in_data(id[3]), .in_mode(im[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]),
    .out_data(od3), .out_ovf(oo[3]),
    .ovf_count(oc3), .ovf_clear(clr[3])
  );

  for (genvar g = 0; g < 4; g++) begin : mon
    localparam int W   = (g == 2) ? 4 : ((g == 3) ? 16 : 8);
    localparam bit SAT = (g == 1) || (g == 3);
    localparam int CMX = (g == 1) ? 3 : 255;
    logic [16:0] q [$];
    logic [16:0] e;

    // Reset discards everything in flight.
    always @(negedge reset_n) begin
      q.delete();
      cnt_m[g] = 0;
      qsize[g] = 0;
    end

    // Handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
      if (reset_n === 1'b1) begin
        chk($sformatf("cnt%0d", g), 32'(oc[g]), 32'(cnt_m[g]));
        chk($sformatf("rdy%0d", g), 32'(ir[g]),
            32'(!ov[g] || ordy[g]));
        if (ov[g] && ordy[g]) begin
          if (q.size() == 0) begin
            chk($sformatf("extra%0d", g), 32'(od[g]), 32'h1_0000);
          end else begin
            e = q.pop_front();
            chk($sformatf("data%0d", g), 32'(od[g]), 32'(e[15:0]));
            chk($sformatf("ovf%0d", g), 32'(oo[g]), 32'(e[16]));
          end
        end
        e = ref_op(W, SAT, im[g], id[g]);
        if (iv[g] && ir[g])
          q.push_back(e);
        if (clr[g])
          cnt_m[g] = 0;
        else if (iv[g] && ir[g] && e[16] && cnt_m[g] < CMX)
          cnt_m[g] = cnt_m[g] + 1;
        qsize[g] = q.size();
      end
    end
  end

  task automatic put(input int g, input logic [15:0] d,
                     input logic [1:0] m);
    iv[g] = 1'b1;
    id[g] = d;
    im[g] = m;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic out_is(input string nm, input int g,
                        input logic [15:0] d, input logic o);
    @(negedge clk);
    chk({nm, "_v"}, 32'(ov[g]), 32'd1);
    chk({nm, "_d"}, 32'(od[g]), 32'(d));
    chk({nm, "_o"}, 32'(oo[g]), 32'(o));
  endtask

  initial begin
    int pend;
    reset_n = 1'b0;
    iv      = '0;
    ordy    = '1;
    clr     = '0;
    for (int i = 0; i < 4; i++) begin
      id[i]    = '0;
      im[i]    = '0;
      cnt_m[i] = 0;
      qsize[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", 32'(ov[i]), 32'd0);
      chk("rst_data", 32'(od[i]), 32'd0);
      chk("rst_ovf", 32'(oo[i]), 32'd0);
      chk("rst_cnt", 32'(oc[i]), 32'd0);
      chk("rst_ready", 32'(ir[i]), 32'd1);
    end

    // Streamed mixed modes, wrap mode.
    step(); put(0, 16'h05, NEG);
    step(); put(0, 16'h80, ABS);
    out_is("s_neg5", 0, 16'hFB, 1'b0);
    step(); put(0, 16'h03, NABS);
    out_is("s_abs80", 0, 16'h80, 1'b1);
    step(); put(0, 16'hFD, PASS);
    out_is("s_nabs3", 0, 16'hFD, 1'b0);
    step(); iv[0] = 1'b0;
    out_is("s_pass", 0, 16'hFD, 1'b0);
    chk("s_cnt", 32'(oc[0]), 32'd1);

    // Saturating variant.
    step(); put(1, 16'h80, NEG);
    step(); put(1, 16'h00, NEG);
    out_is("t_neg80", 1, 16'h7F, 1'b1);
    step(); put(1, 16'h80, NABS);
    out_is("t_neg0", 1, 16'h00, 1'b0);
    step(); iv[1] = 1'b0;
    out_is("t_nabs80", 1, 16'h80, 1'b0);
    chk("t_cnt1", 32'(oc[1]), 32'd1);

    // Counter saturation, then clear racing an overflow.
    step(); put(1, 16'h80, ABS);
    repeat (4) step();
    iv[1] = 1'b0;
    @(negedge clk);
    chk("c_sat", 32'(oc[1]), 32'd3);
    step(); step();
    chk("c_hold", 32'(oc[1]), 32'd3);
    clr[1] = 1'b1;
    put(1, 16'h80, NEG);
    step(); clr[1] = 1'b0; iv[1] = 1'b0;
    @(negedge clk);
    chk("c_clr", 32'(oc[1]), 32'd0);

    // Backpressure holds result and blocks the next operand.
    step(); put(0, 16'h10, NEG);
    step(); ordy[0] = 1'b0; put(0, 16'h20, NEG);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(ir[0]), 32'd0);
      chk("bp_data", 32'(od[0]), 32'hF0);
      chk("bp_valid", 32'(ov[0]), 32'd1);
      step();
    end
    ordy[0] = 1'b1;
    step(); iv[0] = 1'b0;
    out_is("bp_next", 0, 16'hE0, 1'b0);

    // Asynchronous reset while a result is stalled.
    step(); put(0, 16'h80, NEG);
    step(); iv[0] = 1'b0; ordy[0] = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(ov[0]), 32'd0);
    chk("ar_data", 32'(od[0]), 32'd0);
    chk("ar_ovf", 32'(oo[0]), 32'd0);
    chk("ar_cnt", 32'(oc[0]), 32'd0);
    chk("ar_ready", 32'(ir[0]), 32'd1);
    #1 reset_n = 1'b1;
    ordy[0] = 1'b1;
    step(); put(0, 16'h07, NEG);
    step(); iv[0] = 1'b0;
    out_is("ar_next", 0, 16'hF9, 1'b0);

    // Randomized traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int g = 0; g < 4; g++) begin
        iv[g]   = ($urandom_range(0, 3) != 0);
        ordy[g] = ($urandom_range(0, 3) != 0);
        im[g]   = 2'($urandom_range(0, 3));
        id[g]   = 16'($urandom);
        if ($urandom_range(0, 5) == 0)
          id[g] = 16'(1) << (width_of(g) - 1);
        clr[g]  = ($urandom_range(0, 199) == 0);
      end
    end
    step();
    iv   = '0;
    clr  = '0;
    ordy = '1;

    pend = 1;
    for (int c = 0; c < 20 && pend != 0; c++) begin
      @(negedge clk);
      #1;
      pend = qsize[0] + qsize[1] + qsize[2] + qsize[3];
    end
    chk("drain", 32'(pend), 32'd0);
    for (int g = 0; g < 4; g++)
      chk("final_cnt", 32'(oc[g]), 32'(cnt_m[g]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
